// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder tree: log2 of the operand count, the
// per-level sum width, and the layout of the flattened level bus.
package pipelined_adder_pkg;

  // Integer log2 for power-of-two operand counts.
  function automatic int log2(input int n);
    int r;
    int v;
    r = 0;
    v = n;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  // Each level widens the sums by exactly one bit.
  function automatic int stage_width(input int width, input int s);
    return width + s;
  endfunction

  // Total bits held at level s: N/2^s sums of width WIDTH+s.
  function automatic int level_bits(input int width, input int n, input int s);
    return (n >> s) * stage_width(width, s);
  endfunction

  // Levels are packed back to back in one bus, level 0 (the operands) first.
  function automatic int level_offset(input int width, input int n, input int s);
    int off;
    off = 0;
    for (int j = 0; j < s; j++) begin
      off += level_bits(width, n, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered level of the adder tree: PAIRS pair sums, one bit wider than
// the inputs. Define PIPELINED_ADDER_SIGNED_EN for two's complement operands.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int PAIRS    = 2,
  parameter int IN_WIDTH = 4,
  localparam int OUT_W   = stage_width(IN_WIDTH, 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*PAIRS*IN_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PAIRS*OUT_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [PAIRS*OUT_W-1:0] sums;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_WIDTH-1:0] v);
`ifdef PIPELINED_ADDER_SIGNED_EN
    return {v[IN_WIDTH-1], v};
`else
    return {1'b0, v};
`endif
  endfunction

  // The level can take a new beat when it is empty or its content leaves now.
  assign in_ready = !out_valid || out_ready;

  // NOTE: default the whole vector before the loop so no bit is left unassigned on any path (no latch).
  always_comb begin
    sums = '0;
    for (int p = 0; p < PAIRS; p++) begin
      sums[p*OUT_W +: OUT_W] = extend(in_data[(2*p)*IN_WIDTH +: IN_WIDTH])
                             + extend(in_data[(2*p+1)*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // NOTE: state updates use non-blocking assignments so every level samples its upstream pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, since out_data must read 0 after reset.
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= sums;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined adder tree: log2(N_INPUTS) registered levels summing
// N_INPUTS operands. Define PIPELINED_ADDER_SIGNED_EN for signed arithmetic.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int N_INPUTS  = 4,
  localparam int STAGES   = log2(N_INPUTS),
  localparam int OUT_WIDTH = stage_width(WIDTH, STAGES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_INPUTS*WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int BUS_BITS = level_offset(WIDTH, N_INPUTS, STAGES + 1);

  logic [BUS_BITS-1:0] level_bus;
  logic [STAGES:0]     valid;
  logic [STAGES:0]     ready;

  assign level_bus[0 +: N_INPUTS*WIDTH] = in_data;
  assign valid[0]      = in_valid;
  assign in_ready      = ready[0];
  assign ready[STAGES] = out_ready;
  assign out_valid     = valid[STAGES];
  assign out_data      = level_bus[level_offset(WIDTH, N_INPUTS, STAGES) +: OUT_WIDTH];

  for (genvar s = 1; s <= STAGES; s++) begin : gen_level
    localparam int IN_OFF  = level_offset(WIDTH, N_INPUTS, s - 1);
    localparam int IN_BITS = level_bits(WIDTH, N_INPUTS, s - 1);
    localparam int OUT_OFF = level_offset(WIDTH, N_INPUTS, s);
    localparam int OUT_BITS = level_bits(WIDTH, N_INPUTS, s);

    adder_stage #(
      .PAIRS    (N_INPUTS >> s),
      .IN_WIDTH (stage_width(WIDTH, s - 1))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_data   (level_bus[IN_OFF +: IN_BITS]),
      .in_valid  (valid[s-1]),
      .in_ready  (ready[s-1]),
      .out_data  (level_bus[OUT_OFF +: OUT_BITS]),
      .out_valid (valid[s]),
      .out_ready (ready[s])
    );
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors on a 4x4-bit tree and a random
// stream on an 8x8-bit tree, both checked against an arithmetic reference sum.
module tb_pipelined_adder;

  logic clk;
  logic rst;

  logic [15:0] a_in_data;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [5:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [63:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [10:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_adder #(.WIDTH(4), .N_INPUTS(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  pipelined_adder #(.WIDTH(8), .N_INPUTS(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum of n operands of w bits, reduced to ow bits.
  function automatic logic [63:0] ref_sum(input logic [63:0] data, input int w, input int n, input int ow);
    longint acc;
    longint op;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      op = 0;
      for (int b = 0; b < w; b++) begin
        if (data[i*w + b]) op += (longint'(1) << b);
      end
`ifdef PIPELINED_ADDER_SIGNED_EN
      if (data[i*w + w - 1]) op -= (longint'(1) << w);
`endif
      acc += op;
    end
    return 64'(acc) & ((64'd1 << ow) - 64'd1);
  endfunction

  // Scoreboards: expected results in acceptance order.
  logic [63:0] a_model[$];
  logic [63:0] b_model[$];
  int          b_n_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      a_model.delete();
      b_model.delete();
    end else begin
      if (a_out_valid) begin
        if (a_model.size() == 0) check("a_unexpected_valid", 64'(a_out_valid), 64'd0);
        else begin
          check("a_model_sum", 64'(a_out_data), a_model[0]);
          if (a_out_ready) void'(a_model.pop_front());
        end
      end
      if (a_in_valid && a_in_ready) a_model.push_back(ref_sum(64'(a_in_data), 4, 4, 6));

      if (b_out_valid) begin
        if (b_model.size() == 0) check("b_unexpected_valid", 64'(b_out_valid), 64'd0);
        else begin
          check("b_model_sum", 64'(b_out_data), b_model[0]);
          if (b_out_ready) begin
            void'(b_model.pop_front());
            b_n_out++;
          end
        end
      end
      if (b_in_valid && b_in_ready) b_model.push_back(ref_sum(b_in_data, 8, 8, 11));
    end
  end

  // Directed driver for dut_a: beats queued, handshakes recorded with cycle stamps.
  logic [15:0] a_beats[$];
  logic [5:0]  a_got_val[$];
  int          a_got_cyc[$];
  int          a_acc_cyc[$];
  int          cyc = 0;

  task automatic drive_a();
    a_in_valid = (a_beats.size() > 0);
    a_in_data  = (a_beats.size() > 0) ? a_beats[0] : 16'h0;
  endtask

  task automatic clear_rec();
    a_got_val.delete();
    a_got_cyc.delete();
    a_acc_cyc.delete();
  endtask

  task automatic cycle_a();
    logic acc;
    @(negedge clk);
    acc = a_in_valid && a_in_ready;
    if (acc) a_acc_cyc.push_back(cyc);
    if (a_out_valid && a_out_ready) begin
      a_got_val.push_back(a_out_data);
      a_got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) void'(a_beats.pop_front());
    drive_a();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  kk;
    logic        acc;
    int          b_sent;
    int          guard;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_out_data", 64'(a_out_data), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_a_in_ready", 64'(a_in_ready), 64'd1);

    // All operands 15 (signed: -1): 60 / 6'b111100 after exactly 2 cycles
    clear_rec();
    a_beats.push_back(16'hFFFF);
    drive_a();
    repeat (6) cycle_a();
    check("t1_count", 64'(a_got_val.size()), 64'd1);
    if (a_got_val.size() >= 1 && a_acc_cyc.size() >= 1) begin
      check("t1_sum", 64'(a_got_val[0]), 64'd60);
      check("t1_latency", 64'(a_got_cyc[0] - a_acc_cyc[0]), 64'd2);
    end

    // Operands 7, 7, 8(-8), 8(-8)
    clear_rec();
    a_beats.push_back(16'h8877);
    drive_a();
    repeat (6) cycle_a();
    check("t1b_count", 64'(a_got_val.size()), 64'd1);
    if (a_got_val.size() >= 1) begin
`ifdef PIPELINED_ADDER_SIGNED_EN
      check("t1b_sum", 64'(a_got_val[0]), 64'd62);
`else
      check("t1b_sum", 64'(a_got_val[0]), 64'd30);
`endif
    end

    // Stream 1,2,3,4 -> 4,8,12,16 on consecutive cycles
    clear_rec();
    for (int k = 1; k <= 4; k++) begin
      kk = 4'(k);
      a_beats.push_back({kk, kk, kk, kk});
    end
    drive_a();
    repeat (8) cycle_a();
    check("t2_count", 64'(a_got_val.size()), 64'd4);
    if (a_got_val.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t2_sum", 64'(a_got_val[i]), 64'(4 * (i + 1)));
        check("t2_back_to_back", 64'(a_got_cyc[i] - a_got_cyc[0]), 64'(i));
      end
      check("t2_latency", 64'(a_got_cyc[0] - a_acc_cyc[0]), 64'd2);
    end

    // Backpressure: 2 beats accepted, then stall; drain in order, then accept again
    clear_rec();
    a_out_ready = 1'b0;
    a_beats.push_back(16'h4321);
    a_beats.push_back(16'h3333);
    a_beats.push_back(16'h0005);
    drive_a();
    repeat (6) cycle_a();
    check("t3_accepted_stalled", 64'(a_acc_cyc.size()), 64'd2);
    check("t3_in_ready_low", 64'(a_in_ready), 64'd0);
    check("t3_out_valid_held", 64'(a_out_valid), 64'd1);
    check("t3_out_data_held", 64'(a_out_data), 64'd10);
    a_out_ready = 1'b1;
    repeat (6) cycle_a();
    check("t3_accepted_total", 64'(a_acc_cyc.size()), 64'd3);
    check("t3_drained", 64'(a_got_val.size()), 64'd3);
    if (a_got_val.size() == 3 && a_acc_cyc.size() == 3) begin
      check("t3_first", 64'(a_got_val[0]), 64'd10);
      check("t3_second", 64'(a_got_val[1]), 64'd12);
      check("t3_third", 64'(a_got_val[2]), 64'd5);
      check("t3_no_bubble", 64'(a_acc_cyc[2]), 64'(a_got_cyc[0]));
    end

    // Reset with 2 beats in flight
    clear_rec();
    a_out_ready = 1'b0;
    a_beats.push_back(16'h1111);
    a_beats.push_back(16'h2222);
    drive_a();
    repeat (2) cycle_a();
    check("t4_in_flight", 64'(a_acc_cyc.size()), 64'd2);
    rst = 1'b1;
    a_beats.delete();
    drive_a();
    #1;
    check("t4_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("t4_rst_out_data", 64'(a_out_data), 64'd0);
    check("t4_rst_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_rec();
    a_out_ready = 1'b1;
    a_beats.push_back(16'h0421);
    drive_a();
    repeat (6) cycle_a();
    check("t4_count", 64'(a_got_val.size()), 64'd1);
    if (a_got_val.size() >= 1 && a_acc_cyc.size() >= 1) begin
      check("t4_sum", 64'(a_got_val[0]), 64'd7);
      check("t4_latency", 64'(a_got_cyc[0] - a_acc_cyc[0]), 64'd2);
    end

    // 1000 random beats with random backpressure on the 8x8 tree
    b_sent = 0;
    guard  = 0;
    while ((b_sent < 1000 || b_n_out < 1000) && guard < 20000) begin
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (acc) b_sent++;
      if (!b_in_valid || acc) begin
        if (b_sent < 1000 && $urandom_range(3) != 0) begin
          b_in_valid = 1'b1;
          b_in_data  = ($urandom_range(9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        end else begin
          b_in_valid = 1'b0;
        end
      end
      b_out_ready = 1'($urandom_range(1));
      guard++;
    end
    check("b_accepted", 64'(b_sent), 64'd1000);
    check("b_results", 64'(b_n_out), 64'd1000);
    check("b_model_empty", 64'(b_model.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the operand width in bits (WIDTH >= 1).
REQ-002 The block SHALL take parameter N_INPUTS, default 4, as the operand count; a power of two, >= 2.
REQ-003 The block SHALL derive localparam STAGES = log2(N_INPUTS) and OUT_WIDTH = WIDTH + STAGES.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_data  input  N_INPUTS*WIDTH  packed operands; operand i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  1  in_data holds a beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_data  output  OUT_WIDTH  sum of all operands of one beat.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-012 A beat SHALL be accepted when in_valid && in_ready, and a result consumed when out_valid && out_ready.
REQ-013 The datapath SHALL be a binary tree of STAGES registered levels; level s holds N_INPUTS/2^s pair sums of width WIDTH+s plus one valid bit.
REQ-014 Each level SHALL widen by exactly one bit, so no overflow or truncation occurs at any level.
REQ-015 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with out_ready held high.
REQ-016 Throughput SHALL be one beat per cycle while out_ready is high.
REQ-017 Level k SHALL load when ready_k = !valid_k || ready_(k+1), with ready_STAGES = out_ready and in_ready = ready_0.
REQ-018 A level whose valid is set and which cannot advance SHALL hold its data unchanged.
REQ-019 With out_ready low, the block SHALL accept exactly STAGES beats, then deassert in_ready in the same cycle the first level fills.
REQ-020 Full pipe with out_ready high and in_valid high SHALL consume and accept in the same cycle without a bubble.
REQ-021 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-022 out_data SHALL be driven from the last-level register; no combinational path from in_data to out_data.
REQ-023 in_data and in_valid SHALL be ignored while in_ready is low.

Reset
REQ-024 On rst high, all valid bits SHALL clear immediately; out_valid = 0 and out_data = 0.
REQ-025 in_ready SHALL read 1 during and after reset (pipe empty).
REQ-026 Reset mid-operation SHALL discard all in-flight beats; the first beat after rst falls is the next result.

Configuration
REQ-027 Macro PIPELINED_ADDER_SIGNED_EN SHALL select the operand arithmetic.
REQ-028 With PIPELINED_ADDER_SIGNED_EN defined, operands and sums SHALL be two's complement, sign-extended one bit per level.
REQ-029 Without it, operands and sums SHALL be unsigned, zero-extended one bit per level.

Structure
REQ-030 Package pipelined_adder_pkg SHALL hold the log2 function and the stage-width helper (WIDTH+s).
REQ-031 One sub-module, adder_stage, SHALL implement a single level: parameterised pair count and input width, registered sums, valid bit, local ready.
REQ-032 The top SHALL instantiate STAGES adder_stage instances with a generate loop; no other logic beyond wiring.

Verification
REQ-033 The bench SHALL run WIDTH=4, N_INPUTS=4, unsigned: all operands 15, out_ready=1 -> out_data=60 (6'b111100), out_valid exactly 2 cycles after acceptance.
REQ-034 The bench SHALL stream beats 1,2,3,4 (operands all equal to the beat number), out_ready=1 -> results 4,8,12,16 on consecutive cycles.
REQ-035 The bench SHALL hold out_ready=0 and in_valid=1 -> in_ready drops after 2 accepted beats; raising out_ready drains both in order, then accepts again.
REQ-036 The bench SHALL assert rst with 2 beats in flight -> out_valid=0, out_data=0, in_ready=1 at once; the next beat of sum 7 emerges 2 cycles after acceptance.
REQ-037 The bench SHALL run the same scenario with PIPELINED_ADDER_SIGNED_EN: operands -1, -1, -1, -1 -> out_data=-4 (6'b111100); operands 7, 7, -8, -8 -> -2.
REQ-038 The bench SHALL run WIDTH=8, N_INPUTS=8 with 1000 random beats and random out_ready -> every result matches the reference sum, in order.
